// File: rtl/rc4_prga_decrypt_param.sv
// rc4_prga_decrypt_param: RC4 keystream (PRGA) decrypt engine.
// Reads the S-box, performs the i/j swap, XORs the keystream byte with the
// ciphertext ROM and writes the plaintext RAM. The S RAM, ciphertext ROM and
// plaintext RAM each have their own port, so ct[k] is fetched while S[i] is read.
// All reads take RD_LAT cycles from address to sample.
// Optional feature macro: PT_CHECK_EN (abort on a plaintext byte that is not a
// lowercase letter or a space; clears key_valid).
module rc4_prga_decrypt_param #(
  parameter int MSG_AW = 5,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [MSG_AW-1:0] msg_len,
  output logic              busy,
  output logic              done,
  output logic              key_valid,
  output logic [7:0]        s_addr,
  output logic [7:0]        s_wdata,
  output logic              s_wren,
  input  logic [7:0]        s_rdata,
  output logic [MSG_AW-1:0] ct_addr,
  input  logic [7:0]        ct_rdata,
  output logic [MSG_AW-1:0] pt_addr,
  output logic [7:0]        pt_wdata,
  output logic              pt_wren
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT,
    ST_INC_I,
    ST_RD_SI,
    ST_ADD_J,
    ST_RD_SJ,
    ST_WR_SI,
    ST_WR_SJ,
    ST_RD_F,
    ST_WR_PT,
    ST_DONE
  } state_e;

  // Dwell counter width: counts 0 .. RD_LAT-1 inside each read state.
  localparam int              CW         = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CW-1:0]   DWELL_LAST = CW'(RD_LAT - 1);

  state_e            state_q, state_d;
  logic [7:0]        i_q, i_d;
  logic [7:0]        j_q, j_d;
  logic [MSG_AW-1:0] k_q, k_d;
  logic [MSG_AW-1:0] len_q, len_d;
  logic [7:0]        si_q, si_d;
  logic [7:0]        sj_q, sj_d;
  logic [7:0]        f_q, f_d;
  logic [7:0]        ct_q, ct_d;
  logic [CW-1:0]     dwell_q, dwell_d;
  logic              key_valid_q, key_valid_d;

  logic              rd_last;
  logic [7:0]        pt_byte;
  logic              pt_ok;

  assign rd_last = (dwell_q == DWELL_LAST);
  assign pt_byte = f_q ^ ct_q;

`ifdef PT_CHECK_EN
  // Accept only 'a'..'z' and space as plausible plaintext.
  assign pt_ok = ((pt_byte >= 8'h61) && (pt_byte <= 8'h7A)) || (pt_byte == 8'h20);
`else
  assign pt_ok = 1'b1;
`endif

  // State and datapath registers; reset returns to IDLE with everything cleared.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      len_q       <= '0;
      si_q        <= '0;
      sj_q        <= '0;
      f_q         <= '0;
      ct_q        <= '0;
      dwell_q     <= '0;
      key_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      len_q       <= len_d;
      si_q        <= si_d;
      sj_q        <= sj_d;
      f_q         <= f_d;
      ct_q        <= ct_d;
      dwell_q     <= dwell_d;
      key_valid_q <= key_valid_d;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    // NOTE: every target gets a default first so no latch can be inferred.
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    len_d       = len_q;
    si_d        = si_q;
    sj_d        = sj_q;
    f_d         = f_q;
    ct_d        = ct_q;
    dwell_d     = '0;
    key_valid_d = key_valid_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d   = msg_len;
          state_d = ST_INIT;
        end
      end
      ST_INIT: begin
        i_d         = '0;
        j_d         = '0;
        k_d         = '0;
        key_valid_d = 1'b1;
        state_d     = ST_INC_I;
      end
      ST_INC_I: begin
        i_d     = i_q + 8'd1;
        state_d = ST_RD_SI;
      end
      ST_RD_SI: begin
        if (rd_last) begin
          si_d    = s_rdata;
          ct_d    = ct_rdata;
          state_d = ST_ADD_J;
        end else begin
          dwell_d = dwell_q + CW'(1);
        end
      end
      ST_ADD_J: begin
        j_d     = j_q + si_q;
        state_d = ST_RD_SJ;
      end
      ST_RD_SJ: begin
        if (rd_last) begin
          sj_d    = s_rdata;
          state_d = ST_WR_SI;
        end else begin
          dwell_d = dwell_q + CW'(1);
        end
      end
      ST_WR_SI: state_d = ST_WR_SJ;
      ST_WR_SJ: state_d = ST_RD_F;
      ST_RD_F: begin
        if (rd_last) begin
          f_d     = s_rdata;
          state_d = ST_WR_PT;
        end else begin
          dwell_d = dwell_q + CW'(1);
        end
      end
      ST_WR_PT: begin
        if (!pt_ok) begin
          key_valid_d = 1'b0;
          state_d     = ST_DONE;
        end else if (k_q == len_q) begin
          state_d = ST_DONE;
        end else begin
          k_d     = k_q + MSG_AW'(1);
          state_d = ST_INC_I;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore output decode from the registered state and datapath.
  always_comb begin
    s_addr   = i_q;
    s_wdata  = sj_q;
    s_wren   = 1'b0;
    ct_addr  = k_q;
    pt_addr  = k_q;
    pt_wdata = pt_byte;
    pt_wren  = 1'b0;

    unique case (state_q)
      ST_RD_SJ: s_addr = j_q;
      ST_WR_SI: begin
        s_addr  = i_q;
        s_wdata = sj_q;
        s_wren  = 1'b1;
      end
      ST_WR_SJ: begin
        s_addr  = j_q;
        s_wdata = si_q;
        s_wren  = 1'b1;
      end
      ST_RD_F:  s_addr  = si_q + sj_q;
      ST_WR_PT: pt_wren = pt_ok;
      default: ;
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign key_valid = key_valid_q;

endmodule
